tail_light_seq: RTL and testbench
=================================

TAIL_LIGHT_SEQ -- requirements
Module: tail_light_seq

Interface
REQ-001 SHALL have parameter LAMPS, default 3, lamps per side (legal 2..8); index 0 innermost, LAMPS-1 outermost.
REQ-002 SHALL have parameter TICK_DIV, default 1000000, clock cycles per animation step (legal >=2).
REQ-003 SHALL have parameter SEQ_MODE, default 1: 1 = sequential sweep, 0 = whole-side flash.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clock  in  1  system clock; all state on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 left_req  in  1  left turn request, level.
REQ-008 right_req  in  1  right turn request, level.
REQ-009 hazard  in  1  hazard request, level.
REQ-010 brake  in  1  brake pedal, level.
REQ-011 left_lamps  out  LAMPS  left lamp drive, 1 = lit.
REQ-012 right_lamps  out  LAMPS  right lamp drive, 1 = lit.
REQ-013 mode_code  out  2  current FSM state encoding.

Function
REQ-014 Tick generator SHALL count 0..TICK_DIV-1 and wrap to 0; tick is a one-cycle pulse when count = TICK_DIV-1.
REQ-015 FSM states and encodings SHALL be IDLE=0, LEFT=1, RIGHT=2, HAZARD=3; mode_code SHALL equal the state register.
REQ-016 Next state, evaluated every cycle: hazard -> HAZARD; else left_req & ~right_req -> LEFT; else right_req & ~left_req -> RIGHT; else IDLE (both requests together -> IDLE).
REQ-017 State register SHALL update one cycle after the input change (one-cycle latency).
REQ-018 On any state change, the step counter and tick counter SHALL clear to 0 on the same edge the new state loads.
REQ-019 SEQ_MODE=1: step counter SHALL run 0..LAMPS and advance on tick, wrapping LAMPS -> 0; pattern bit i is lit iff i < step (step 0 all off, step LAMPS all on).
REQ-020 SEQ_MODE=0: step counter SHALL toggle 0/1 on tick; pattern is all-ones when step=1, else all-zeros.
REQ-021 Step counter SHALL hold at 0 in IDLE.
REQ-022 brake SHALL be registered once (brake_q); outputs use brake_q only.
REQ-023 Outputs SHALL be a combinational decode of state, step, brake_q: IDLE -> both sides all-ones if brake_q, else zero.
REQ-024 LEFT -> left = pattern; right = all-ones if brake_q, else zero. RIGHT is the mirror image.
REQ-025 HAZARD -> both sides = the same pattern in lockstep; if brake_q, both sides all-ones steady while the step counter keeps running.
REQ-026 Counter widths SHALL be clog2-sized from TICK_DIV and LAMPS+1; no overflow past the wrap values.

Reset
REQ-027 While reset is high at a clock edge: state=IDLE, step=0, tick count=0, brake_q=0; hence left_lamps=0, right_lamps=0, mode_code=0.
REQ-028 Reset SHALL override all requests, including mid-sweep; the first step after release starts at 0 with a full TICK_DIV period.

Structure
REQ-029 State encodings and the mode_code width SHALL be localparams in shared package tail_light_pkg.
REQ-030 The tick generator SHALL be a sub-module, tail_tick_gen (params DIV; ports clock, reset, clear, tick).
REQ-031 Target size: 120-400 lines of RTL total.

Verification (LAMPS=3, TICK_DIV=4 unless noted)
REQ-032 Reset, then left_req=1 held -> left_lamps 000,001,011,111,000,... each held 4 cycles; right_lamps=000; mode_code=1.
REQ-033 right_req=1, brake=1 -> right sweeps 000..111; left_lamps=111 from the cycle after brake_q sets.
REQ-034 Switch left_req->right_req at step 2 -> next cycle left=000, right=000, mode_code=2; right reaches 001 four cycles later.
REQ-035 hazard=1 with left_req=1 -> both sides sweep identically, mode_code=3; add brake -> both 111; drop brake -> sweep resumes at the current step.
REQ-036 left_req=right_req=1 -> IDLE, lamps 000; brake=1 -> both 111; reset pulse mid-sweep -> all outputs 0 on the next edge.
REQ-037 SEQ_MODE=0, left_req=1 -> left_lamps alternates 000/111 every 4 cycles.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared encodings for the tail-light sequencer: FSM state values and the
// width of the mode_code port that exposes the state register.
package tail_light_pkg;
  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [MODE_W-1:0] ST_LEFT   = 2'd1;
  localparam logic [MODE_W-1:0] ST_RIGHT  = 2'd2;
  localparam logic [MODE_W-1:0] ST_HAZARD = 2'd3;
endpackage

// File: rtl/tail_tick_gen.sv
// Animation tick generator: free-running 0..DIV-1 counter with a one-cycle
// tick on the last count; clear restarts the period from zero.
module tail_tick_gen #(
  parameter int DIV = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + CNT_W'(1);
  end

  assign tick = (count == LAST);
endmodule

// File: rtl/tail_light_seq.sv
// Turn/hazard/brake tail-light sequencer: a four-state FSM selects which side
// animates; a step counter advanced by tail_tick_gen drives sweep or flash.
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 1000000,
  parameter int SEQ_MODE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              left_req,
  input  logic              right_req,
  input  logic              hazard,
  input  logic              brake,
  output logic [LAMPS-1:0]  left_lamps,
  output logic [LAMPS-1:0]  right_lamps,
  output logic [MODE_W-1:0] mode_code
);
  localparam int STEP_W = $clog2(LAMPS + 1);
  // Sweep runs 0..LAMPS; flash only toggles between 0 and 1.
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((SEQ_MODE != 0) ? LAMPS : 1);

  logic [MODE_W-1:0] state;
  logic [MODE_W-1:0] next_state;
  logic [STEP_W-1:0] step;
  logic [LAMPS-1:0]  pattern;
  logic              brake_q;
  logic              tick;
  logic              change;

  assign change = (next_state != state);

  tail_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(change),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = ST_IDLE;
    if (hazard)
      next_state = ST_HAZARD;
    else if (left_req && !right_req)
      next_state = ST_LEFT;
    else if (right_req && !left_req)
      next_state = ST_RIGHT;
  end

  // A state change restarts the animation so every new mode begins dark.
  always_ff @(posedge clock) begin
    if (reset)
      step <= '0;
    else if (change || state == ST_IDLE)
      step <= '0;
    else if (tick)
      step <= (step == STEP_LAST) ? '0 : step + STEP_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)
      brake_q <= 1'b0;
    else
      brake_q <= brake;
  end

  always_comb begin
    pattern = '0;
    for (int i = 0; i < LAMPS; i++) begin
      if (SEQ_MODE != 0)
        pattern[i] = (i < int'(step));
      else
        pattern[i] = (step == STEP_W'(1));
    end
  end

  always_comb begin
    left_lamps  = brake_q ? '1 : '0;
    right_lamps = brake_q ? '1 : '0;
    case (state)
      ST_LEFT:   left_lamps  = pattern;
      ST_RIGHT:  right_lamps = pattern;
      ST_HAZARD: begin
        left_lamps  = brake_q ? '1 : pattern;
        right_lamps = brake_q ? '1 : pattern;
      end
      default: ;
    endcase
  end

  assign mode_code = state;
endmodule

// File: tb/tb_tail_light_seq.sv
// Scoreboard bench: a model predicts lamp outputs from cycles elapsed since
// the current mode was entered; a negedge monitor compares two configurations.
module tb_tail_light_seq;
  localparam int LA = 3, DA = 4, SA = 1;
  localparam int LB = 4, DB = 3, SB = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_req = 1'b0, right_req = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic [LA-1:0] left_a, right_a;
  logic [LB-1:0] left_b, right_b;
  logic [1:0] mode_a, mode_b;

  typedef struct {
    logic [7:0] l_a, r_a, l_b, r_b;
    logic [1:0] m_a, m_b;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  tail_light_seq #(.LAMPS(LA), .TICK_DIV(DA), .SEQ_MODE(SA)) dut_a (
    .clock(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
    .hazard(hazard), .brake(brake), .left_lamps(left_a), .right_lamps(right_a),
    .mode_code(mode_a)
  );

  tail_light_seq #(.LAMPS(LB), .TICK_DIV(DB), .SEQ_MODE(SB)) dut_b (
    .clock(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
    .hazard(hazard), .brake(brake), .left_lamps(left_b), .right_lamps(right_b),
    .mode_code(mode_b)
  );

  function automatic void model_out(input int st, input int el, input bit bq,
                                    input int lamps, input int div, input int seq,
                                    output logic [7:0] l, output logic [7:0] r);
    logic [7:0] ones, pat, br;
    int stp;
    ones = 8'((1 << lamps) - 1);
    br   = bq ? ones : 8'd0;
    if (seq != 0) begin
      stp = (el / div) % (lamps + 1);
      pat = 8'((1 << stp) - 1);
    end else begin
      stp = (el / div) % 2;
      pat = (stp != 0) ? ones : 8'd0;
    end
    case (st)
      1: begin l = pat; r = br; end
      2: begin l = br;  r = pat; end
      3: begin l = bq ? ones : pat; r = bq ? ones : pat; end
      default: begin l = br; r = br; end
    endcase
  endfunction

  // Reference model: mode chosen by priority, animation from time in mode.
  initial begin
    int st, el, nst;
    bit bq;
    exp_t e;
    st = 0; el = 0; bq = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        st = 0; el = 0; bq = 1'b0;
      end else begin
        if (hazard)                      nst = 3;
        else if (left_req && !right_req) nst = 1;
        else if (right_req && !left_req) nst = 2;
        else                             nst = 0;
        if (nst != st) begin st = nst; el = 0; end
        else el++;
        bq = brake;
      end
      model_out(st, el, bq, LA, DA, SA, e.l_a, e.r_a);
      model_out(st, el, bq, LB, DB, SB, e.l_b, e.r_b);
      e.m_a = 2'(st);
      e.m_b = 2'(st);
      q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({5'd0, left_a} !== e.l_a || {5'd0, right_a} !== e.r_a || mode_a !== e.m_a) begin
          n_fail++;
          $display("FAIL sweep_cfg cyc %0d: left=%b right=%b mode=%0d, required left=%b right=%b mode=%0d",
                   cyc, left_a, right_a, mode_a, e.l_a[LA-1:0], e.r_a[LA-1:0], e.m_a);
        end
        n_checks++;
        if ({4'd0, left_b} !== e.l_b || {4'd0, right_b} !== e.r_b || mode_b !== e.m_b) begin
          n_fail++;
          $display("FAIL flash_cfg cyc %0d: left=%b right=%b mode=%0d, required left=%b right=%b mode=%0d",
                   cyc, left_b, right_b, mode_b, e.l_b[LB-1:0], e.r_b[LB-1:0], e.m_b);
        end
      end
    end
  end

  task automatic hold(input int n, input bit rs, input bit l, input bit r,
                      input bit h, input bit b);
    reset = rs; left_req = l; right_req = r; hazard = h; brake = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    hold(3, 1, 0, 0, 0, 0);
    hold(20, 0, 1, 0, 0, 0);   // left sweep
    hold(2, 0, 0, 0, 0, 0);
    hold(20, 0, 0, 1, 0, 1);   // right sweep with brake
    hold(2, 0, 0, 0, 0, 0);
    hold(9, 0, 1, 0, 0, 0);    // switch mid-sweep
    hold(10, 0, 0, 1, 0, 0);
    hold(10, 0, 1, 0, 1, 0);   // hazard overrides left
    hold(6, 0, 1, 0, 1, 1);
    hold(10, 0, 1, 0, 1, 0);
    hold(5, 0, 1, 1, 0, 0);    // both requests
    hold(5, 0, 1, 1, 0, 1);
    hold(6, 0, 1, 0, 0, 0);
    hold(1, 1, 1, 0, 0, 0);    // reset mid-sweep
    hold(10, 0, 1, 0, 0, 0);
    repeat (400) begin
      hold($urandom_range(1, 12), ($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    hold(30, 0, 0, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
